// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared constants and state encoding for the Montgomery sequencer
package mont_pkg;

  localparam int MONT_N              = 512;
  localparam int MONT_W              = MONT_N + 2;
  localparam int MONT_RESOLVE_CYCLES = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD_B,
    ST_ADD_M,
    ST_RESOLVE1,
    ST_SUB,
    ST_RESOLVE2,
    ST_RESTORE,
    ST_DONE
  } mont_state_e;

endpackage

// File: rtl/mont_bitcnt.sv
// rtl/mont_bitcnt.sv - operand bit index counter with load, increment and last-bit flag
module mont_bitcnt
  import mont_pkg::*;
#(
  parameter int N = MONT_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 inc_i,
  output logic [$clog2(N)-1:0] cnt_o,
  output logic                 last_o
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/mont_seq.sv
// rtl/mont_seq.sv - bit-serial Montgomery multiplication sequencer driving mpadder
// Build option MONT_SEQ_SKIP_ZERO_EN: skip the add-B cycle for zero bits of A.
module mont_seq
  import mont_pkg::*;
#(
  parameter int N              = MONT_N,
  parameter int RESOLVE_CYCLES = MONT_RESOLVE_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  input  logic         c_lsb,
  input  logic         c_neg,
  output logic [N+1:0] add_in,
  output logic         add_sub,
  output logic         add_shift,
  output logic         add_en,
  output logic         add_carry_en,
  output logic         add_clr,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam int RW = $clog2(RESOLVE_CYCLES + 1);

  mont_state_e   state_q, state_d;
  logic [N-1:0]  a_q, b_q, m_q;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] bit_idx;
  logic          bit_last;
  logic          cnt_load;
  logic          cnt_inc;
  logic          cur_bit;
  logic          res_last;
  logic          capture;

  mont_bitcnt #(
    .N(N)
  ) u_bitcnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .cnt_o  (bit_idx),
    .last_o (bit_last)
  );

  assign capture  = (state_q == ST_IDLE) && start;
  assign cur_bit  = a_q[bit_idx];
  assign res_last = (rcnt_q == RW'(RESOLVE_CYCLES - 1));

`ifdef MONT_SEQ_SKIP_ZERO_EN
  // The counter only clears at the end of LOAD, so bit 0 is looked up directly there.
  logic [CW-1:0] nxt_idx;
  logic          nxt_bit;
  logic          first_bit;
  assign nxt_idx   = bit_idx + CW'(1);
  assign nxt_bit   = a_q[nxt_idx];
  assign first_bit = a_q[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      if (capture) begin
        a_q <= in_a;
        b_q <= in_b;
        m_q <= in_m;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rcnt_d       = '0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    add_in       = '0;
    add_sub      = 1'b0;
    add_shift    = 1'b0;
    add_en       = 1'b0;
    add_carry_en = 1'b0;
    add_clr      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        add_clr  = 1'b1;
        cnt_load = 1'b1;
`ifdef MONT_SEQ_SKIP_ZERO_EN
        state_d  = first_bit ? ST_ADD_B : ST_ADD_M;
`else
        state_d  = ST_ADD_B;
`endif
      end
      ST_ADD_B: begin
        add_in  = cur_bit ? {2'b00, b_q} : '0;
        add_en  = 1'b1;
        state_d = ST_ADD_M;
      end
      ST_ADD_M: begin
        // Only combinational output path: the add-M choice follows the adder's LSB.
        add_in    = c_lsb ? {2'b00, m_q} : '0;
        add_en    = 1'b1;
        add_shift = 1'b1;
        if (bit_last) begin
          state_d = ST_RESOLVE1;
        end else begin
          cnt_inc = 1'b1;
`ifdef MONT_SEQ_SKIP_ZERO_EN
          state_d = nxt_bit ? ST_ADD_B : ST_ADD_M;
`else
          state_d = ST_ADD_B;
`endif
        end
      end
      ST_RESOLVE1: begin
        add_carry_en = 1'b1;
        if (res_last) begin
          state_d = ST_SUB;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_SUB: begin
        add_in  = {2'b00, m_q};
        add_sub = 1'b1;
        add_en  = 1'b1;
        state_d = ST_RESOLVE2;
      end
      ST_RESOLVE2: begin
        add_carry_en = 1'b1;
        if (res_last) begin
          state_d = c_neg ? ST_RESTORE : ST_DONE;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_RESTORE: begin
        add_in  = {2'b00, m_q};
        add_en  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mont_seq.sv
// tb/tb_mont_seq.sv - directed and random bench for mont_seq against a behavioural mpadder
module tb_mont_seq;

  localparam int N = 512;
  localparam int R = 4;
  localparam int W = N + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] in_m = '0;
  logic         c_lsb;
  logic         c_neg;
  logic [W-1:0] add_in;
  logic         add_sub, add_shift, add_en, add_carry_en, add_clr, busy, done;

  int n_asserts = 0;
  int n_fail    = 0;
  int last_lat;
  int last_restores;
  int lsb_seen;

  mont_seq #(
    .N(N),
    .RESOLVE_CYCLES(R)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_m         (in_m),
    .c_lsb        (c_lsb),
    .c_neg        (c_neg),
    .add_in       (add_in),
    .add_sub      (add_sub),
    .add_shift    (add_shift),
    .add_en       (add_en),
    .add_carry_en (add_carry_en),
    .add_clr      (add_clr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Behavioural mpadder: add or subtract, optional halving, carries always resolved.
  logic [W-1:0] acc = '0;
  wire  [W-1:0] mdl_sum = add_sub ? (acc - add_in) : (acc + add_in);
  wire  [6:0]   ctrl = {add_sub, add_shift, add_en, add_carry_en, add_clr, busy, done};
  assign c_lsb = acc[0];
  assign c_neg = acc[W-1];

  always @(posedge clk) begin
    if (add_clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= add_shift ? (mdl_sum >> 1) : mdl_sum;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // A*B mod M by shift-and-add, then N modular halvings to apply 2^-N.
  function automatic logic [N-1:0] ref_mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    logic [W-1:0] x, mm, bb;
    x  = '0;
    mm = {2'b00, m};
    bb = {2'b00, b};
    for (int i = N - 1; i >= 0; i--) begin
      x = x << 1;
      if (x >= mm) x = x - mm;
      if (a[i]) begin
        x = x + bb;
        if (x >= mm) x = x - mm;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (x[0]) x = x + mm;
      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                        input bit extra, input string tag);
    logic [N-1:0] expv;
    logic [W-1:0] exp_b;
    logic         decided, neg_at;
    int k, lat, dones, busy_cyc, shifts, restores, subs, bad_b, bad_m, addb, idle_bad;
    int steps, exp_addb, exp_lat;
    expv = ref_mont(a, b, m);
    lat = 0; dones = 0; busy_cyc = 0; shifts = 0; restores = 0; subs = 0;
    bad_b = 0; bad_m = 0; addb = 0; idle_bad = 0; decided = 1'b0; neg_at = 1'b0;
    lsb_seen = 0;
    in_a = a; in_b = b; in_m = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_a = rand_vec(); in_b = rand_vec(); in_m = rand_vec();
    chk({tag, "_load_clr"}, W'(add_clr), W'(1));
    k = 1;
    while (k <= 3000 && !(lat > 0 && k > lat + 20)) begin
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        if (lat == 0) lat = k;
      end
      if (lat > 0 && k > lat && ({ctrl, add_in} != '0)) idle_bad++;
      if (add_en && !add_sub && !add_shift && shifts < N) begin
        exp_b = a[shifts] ? {2'b00, b} : '0;
        addb++;
        if (add_in !== exp_b) bad_b++;
      end
      if (add_shift) begin
        if (add_in !== (c_lsb ? {2'b00, m} : '0)) bad_m++;
        if (c_lsb) lsb_seen++;
        shifts++;
      end
      if (!decided && subs == 1 && !add_carry_en && !add_sub) begin
        decided = 1'b1;
        neg_at  = c_neg;
        if (add_en && !add_shift) restores++;
      end
      if (add_sub) subs++;
      start = (extra && (k == 10 || k == 500)) ? 1'b1 : 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
`ifdef MONT_SEQ_SKIP_ZERO_EN
    steps    = N + $countones(a);
    exp_addb = $countones(a);
`else
    steps    = 2 * N;
    exp_addb = N;
`endif
    exp_lat = 1 + steps + 2 * R + 1 + restores + 1;
    chk({tag, "_done_pulses"}, W'(dones), W'(1));
    chk({tag, "_latency"}, W'(lat), W'(exp_lat));
    chk({tag, "_busy_cycles"}, W'(busy_cyc), W'(lat));
    chk({tag, "_restore_vs_neg"}, W'(restores), W'(neg_at));
    chk({tag, "_sub_count"}, W'(subs), W'(1));
    chk({tag, "_addb_cycles"}, W'(addb), W'(exp_addb));
    chk({tag, "_addb_operand_bad"}, W'(bad_b), W'(0));
    chk({tag, "_addm_operand_bad"}, W'(bad_m), W'(0));
    chk({tag, "_idle_outputs_bad"}, W'(idle_bad), W'(0));
    chk({tag, "_result"}, acc, {2'b00, expv});
    last_lat      = lat;
    last_restores = restores;
  endtask

  initial begin
    logic [N-1:0] a, b, m;
    int steps0;

    repeat (3) @(negedge clk);
    chk("reset_add_in", add_in, '0);
    chk("reset_ctrl", W'(ctrl), '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", W'(ctrl), '0);

`ifdef MONT_SEQ_SKIP_ZERO_EN
    steps0 = N;
`else
    steps0 = 2 * N;
`endif
    run_op(N'(0), N'(5), N'(7), 1'b0, "a0");
    chk("a0_total_latency", W'(last_lat), W'(1 + steps0 + 2 * R + 3));
    chk("a0_restore_taken", W'(last_restores), W'(1));
    chk("a0_lsb_ones", W'(lsb_seen), W'(0));

    run_op(N'(1), N'(1), N'(3), 1'b0, "a1");
    chk("a1_result_const", acc, W'(1));

    m = '0;
    m[N-1] = 1'b1;
    m = m + N'(111);
    run_op(m - N'(1), m - N'(1), m, 1'b0, "mm1");

    m = rand_vec();
    m[N-1] = 1'b1;
    m[0] = 1'b1;
    a = rand_vec();
    if (a >= m) a = a - m;
    b = rand_vec();
    if (b >= m) b = b - m;
    run_op(a, b, m, 1'b1, "dbl_start");

    in_a = '1; in_b = b; in_m = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_in_add_m", W'(add_shift), W'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_add_in", add_in, '0);
    chk("mid_reset_ctrl", W'(ctrl), '0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 3; t++) begin
      m = rand_vec();
      m[N-1] = 1'b1;
      m[0] = 1'b1;
      a = rand_vec();
      if (a >= m) a = a - m;
      b = rand_vec();
      if (b >= m) b = b - m;
      run_op(a, b, m, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
